// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Requester ids and the hard-wired zero register live here.
package rf_pkg;

    localparam int AW   = 3;
    localparam int DW   = 16;
    localparam int NREG = 1 << AW;
    localparam int R0   = 0;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard with hazard compare on three addresses.
// Bit 0 is never set; a set and clear of the same register resolve to set.
module rf_scoreboard #(
    parameter int AW = rf_pkg::AW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_v,
    input  logic [AW-1:0]      set_a,
    input  logic               clr_v,
    input  logic [AW-1:0]      clr_a,
    input  logic [AW-1:0]      chk_a1,
    input  logic [AW-1:0]      chk_a2,
    input  logic [AW-1:0]      chk_a3,
    output logic [(1<<AW)-1:0] busy,
    output logic               hazard
);
    import rf_pkg::*;

    logic [(1<<AW)-1:0] busy_q;
    logic [(1<<AW)-1:0] busy_d;

    // next busy vector: clear the landed write, then apply the new allocation
    always_comb begin
        busy_d = busy_q;
        if (clr_v) begin
            busy_d[clr_a] = 1'b0;
        end
        if (set_v && (set_a != AW'(R0))) begin
            busy_d[set_a] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // busy register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign hazard = busy_q[chk_a1] | busy_q[chk_a2] | busy_q[chk_a3];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester write-back arbiter driving the register file write port.
// Define WB_RR_EN for round-robin ties; otherwise A has fixed priority.
module rf_wb_arbiter #(
    parameter int AW = rf_pkg::AW,
    parameter int DW = rf_pkg::DW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic [AW-1:0]      a_addr,
    input  logic [DW-1:0]      a_data,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [AW-1:0]      b_addr,
    input  logic [DW-1:0]      b_data,
    output logic               b_ready,
    input  logic               alloc_v,
    input  logic [AW-1:0]      alloc_a,
    input  logic [AW-1:0]      chk_a1,
    input  logic [AW-1:0]      chk_a2,
    output logic               hazard,
    output logic               we,
    output logic [AW-1:0]      wa,
    output logic [DW-1:0]      wd,
    output logic [(1<<AW)-1:0] busy
);
    import rf_pkg::*;

    logic          gnt_a;
    logic          gnt_b;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [AW-1:0] chk_a3;
    logic          set_v;

`ifdef WB_RR_EN
    req_e lp_q, lp_d;

    // grant: a tie goes to whoever did not win last
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (a_valid && b_valid) begin
                if (lp_q == REQ_B) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = a_valid;
                gnt_b = b_valid;
            end
        end
    end

    // last-grant pointer follows every grant
    always_comb begin
        lp_d = lp_q;
        if (gnt_a) begin
            lp_d = REQ_A;
        end else if (gnt_b) begin
            lp_d = REQ_B;
        end
    end

    // last-grant register; B after reset so A wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            lp_q <= REQ_B;
        end else begin
            lp_q <= lp_d;
        end
    end
`else
    // grant: A always beats B
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            gnt_a = a_valid;
            gnt_b = b_valid && !a_valid;
        end
    end
`endif

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    // output stage: capture the granted write; r0 completes without a write
    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (gnt_a) begin
            we_d = (a_addr != AW'(R0));
            wa_d = a_addr;
            wd_d = a_data;
        end else if (gnt_b) begin
            we_d = (b_addr != AW'(R0));
            wa_d = b_addr;
            wd_d = b_data;
        end
    end

    // write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
        end
    end

    assign we = we_q;
    assign wa = wa_q;
    assign wd = wd_q;

    // r0 is never busy, so an idle allocation port checks against r0
    assign chk_a3 = alloc_v ? alloc_a : AW'(R0);
    assign set_v  = alloc_v && !hazard;

    rf_scoreboard #(.AW(AW)) u_sb (
        .clk    (clk),
        .rst    (rst),
        .set_v  (set_v),
        .set_a  (alloc_a),
        .clr_v  (we_q),
        .clr_a  (wa_q),
        .chk_a1 (chk_a1),
        .chk_a2 (chk_a2),
        .chk_a3 (chk_a3),
        .busy   (busy),
        .hazard (hazard)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model of grant, write and busy rules.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [2:0]  a_addr, b_addr, alloc_a, chk_a1, chk_a2, wa;
    logic [15:0] a_data, b_data, wd;
    logic        alloc_v, hazard, we;
    logic [7:0]  busy;
    logic [15:0] rf [8];

    int n_cmp = 0;
    int n_err = 0;

    rf_wb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .b_ready (b_ready),
        .alloc_v (alloc_v),
        .alloc_a (alloc_a),
        .chk_a1  (chk_a1),
        .chk_a2  (chk_a2),
        .hazard  (hazard),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // register file fixture driven by the write port
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (we) begin
            rf[wa] <= wd;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic idle();
        a_valid = 0; a_addr = 0; a_data = 0;
        b_valid = 0; b_addr = 0; b_data = 0;
        alloc_v = 0; alloc_a = 0; chk_a1 = 0; chk_a2 = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        a_valid = 1; b_valid = 1; a_addr = 3; b_addr = 4;
        next();
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset.a_ready got %0b want 0", a_ready); end
        n_cmp++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL reset.b_ready got %0b want 0", b_ready); end
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL reset.we got %0b want 0", we); end
        n_cmp++; if (wa !== 3'd0 || wd !== 16'd0) begin n_err++; $display("FAIL reset.wa_wd got %0d/%h want 0/0", wa, wd); end
        n_cmp++; if (busy !== 8'h00) begin n_err++; $display("FAIL reset.busy got %h want 00", busy); end
        next();
        idle();
        rst = 0;
    endtask

    task automatic test_a_only();
        a_valid = 1; a_addr = 3; a_data = 16'h1234;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL a_only.ready got %0b%0b want 10", a_ready, b_ready); end
        next();
        a_valid = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== 3'd3 || wd !== 16'h1234) begin n_err++; $display("FAIL a_only.wport got %0b/%0d/%h want 1/3/1234", we, wa, wd); end
        next();
        @(negedge clk);
        n_cmp++; if (rf[3] !== 16'h1234) begin n_err++; $display("FAIL a_only.rf3 got %h want 1234", rf[3]); end
        n_cmp++; if (we !== 1'b0 || wa !== 3'd3 || wd !== 16'h1234) begin n_err++; $display("FAIL a_only.hold got %0b/%0d/%h want 0/3/1234", we, wa, wd); end
    endtask

    task automatic test_tie();
        logic ea;
        logic [2:0] prev_a;
        do_reset();
        a_valid = 1; a_addr = 2; a_data = 16'hAAAA;
        b_valid = 1; b_addr = 5; b_data = 16'hBBBB;
        prev_a = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef WB_RR_EN
            ea = (i % 2 == 0);
`else
            ea = 1'b1;
`endif
            @(negedge clk);
            n_cmp++; if (a_ready !== ea || b_ready !== !ea) begin n_err++; $display("FAIL tie.grant%0d got %0b%0b want %0b%0b", i, a_ready, b_ready, ea, !ea); end
            if (i > 0) begin
                n_cmp++; if (we !== 1'b1 || wa !== prev_a) begin n_err++; $display("FAIL tie.wa%0d got %0b/%0d want 1/%0d", i, we, wa, prev_a); end
            end
            prev_a = ea ? 3'd2 : 3'd5;
            next();
        end
        a_valid = 0;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_err++; $display("FAIL tie.b_alone got %0b%0b want 01", a_ready, b_ready); end
        next();
        idle();
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== 3'd5 || wd !== 16'hBBBB) begin n_err++; $display("FAIL tie.b_write got %0b/%0d/%h want 1/5/bbbb", we, wa, wd); end
        next();
    endtask

    task automatic test_scoreboard();
        alloc_v = 1; alloc_a = 4;
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL sb.alloc_hz got %0b want 0", hazard); end
        next();
        alloc_v = 0; chk_a1 = 4;
        @(negedge clk);
        n_cmp++; if (busy !== 8'h10 || hazard !== 1'b1) begin n_err++; $display("FAIL sb.busy4 got %h/%0b want 10/1", busy, hazard); end
        next();
        b_valid = 1; b_addr = 4; b_data = 16'h4444;
        @(negedge clk);
        n_cmp++; if (b_ready !== 1'b1 || hazard !== 1'b1) begin n_err++; $display("FAIL sb.bgrant got %0b/%0b want 1/1", b_ready, hazard); end
        next();
        b_valid = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== 3'd4 || hazard !== 1'b1) begin n_err++; $display("FAIL sb.inflight got %0b/%0d/%0b want 1/4/1", we, wa, hazard); end
        next();
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b0 || busy !== 8'h00 || rf[4] !== 16'h4444) begin n_err++; $display("FAIL sb.landed got %0b/%h/%h want 0/00/4444", hazard, busy, rf[4]); end
        idle();
        next();
    endtask

    task automatic test_waw();
        alloc_v = 1; alloc_a = 6;
        @(negedge clk);
        n_cmp++; if (hazard !== 1'b0) begin n_err++; $display("FAIL waw.first got %0b want 0", hazard); end
        next();
        @(negedge clk);
        n_cmp++; if (busy !== 8'h40 || hazard !== 1'b1) begin n_err++; $display("FAIL waw.hz got %h/%0b want 40/1", busy, hazard); end
        next();
        alloc_a = 0;
        @(negedge clk);
        n_cmp++; if (busy !== 8'h40 || hazard !== 1'b0) begin n_err++; $display("FAIL waw.r0hz got %h/%0b want 40/0", busy, hazard); end
        next();
        alloc_v = 0;
        a_valid = 1; a_addr = 6; a_data = 16'h6666;
        @(negedge clk);
        n_cmp++; if (busy !== 8'h40 || a_ready !== 1'b1) begin n_err++; $display("FAIL waw.r0alloc got %h/%0b want 40/1", busy, a_ready); end
        next();
        a_valid = 0;
        alloc_v = 1; alloc_a = 2;
        @(negedge clk);
        n_cmp++; if (we !== 1'b1 || wa !== 3'd6 || hazard !== 1'b0) begin n_err++; $display("FAIL waw.clr got %0b/%0d/%0b want 1/6/0", we, wa, hazard); end
        next();
        alloc_v = 0;
        @(negedge clk);
        n_cmp++; if (busy !== 8'h04) begin n_err++; $display("FAIL waw.setclr got %h want 04", busy); end
    endtask

    task automatic test_r0();
        a_valid = 1; a_addr = 0; a_data = 16'hFFFF;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL r0.ready got %0b want 1", a_ready); end
        next();
        a_valid = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b0 || busy !== 8'h04) begin n_err++; $display("FAIL r0.nowrite got %0b/%h want 0/04", we, busy); end
        next();
        @(negedge clk);
        n_cmp++; if (rf[0] !== 16'h0000) begin n_err++; $display("FAIL r0.rf0 got %h want 0000", rf[0]); end
    endtask

    task automatic test_reset_mid();
        a_valid = 1; a_addr = 1; a_data = 16'h1111;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL rmid.grant got %0b want 1", a_ready); end
        next();
        rst = 1;
        a_valid = 1; a_addr = 2; a_data = 16'hAAAA;
        b_valid = 1; b_addr = 5; b_data = 16'hBBBB;
        @(negedge clk);
        n_cmp++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || we !== 1'b1) begin n_err++; $display("FAIL rmid.inrst got %0b%0b/%0b want 00/1", a_ready, b_ready, we); end
        next();
        rst = 0;
        @(negedge clk);
        n_cmp++; if (we !== 1'b0 || busy !== 8'h00) begin n_err++; $display("FAIL rmid.cleared got %0b/%h want 0/00", we, busy); end
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_err++; $display("FAIL rmid.firsttie got %0b%0b want 10", a_ready, b_ready); end
        next();
        idle();
    endtask

    task automatic test_random();
        logic [7:0]  m_busy;
        logic [15:0] m_rf [8];
        logic        m_we, last_b, ea, eb, eh, a_hold, b_hold;
        logic [2:0]  m_wa;
        logic [15:0] m_wd;
        do_reset();
        m_busy = 0; m_we = 0; m_wa = 0; m_wd = 0;
        last_b = 1; a_hold = 0; b_hold = 0;
        for (int i = 0; i < 8; i++) m_rf[i] = 0;
        for (int c = 0; c < 600; c++) begin
            if (!a_hold) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr = 3'($urandom); a_data = 16'($urandom);
            end
            if (!b_hold) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr = 3'($urandom); b_data = 16'($urandom);
            end
            alloc_v = ($urandom_range(0, 3) == 0);
            alloc_a = 3'($urandom);
            chk_a1 = 3'($urandom);
            chk_a2 = 3'($urandom);
            @(negedge clk);
`ifdef WB_RR_EN
            ea = a_valid && (!b_valid || last_b);
`else
            ea = a_valid;
`endif
            eb = b_valid && !ea;
            eh = m_busy[chk_a1] | m_busy[chk_a2] | (alloc_v & m_busy[alloc_a]);
            n_cmp++; if (a_ready !== ea || b_ready !== eb) begin n_err++; $display("FAIL rand.grant c%0d got %0b%0b want %0b%0b", c, a_ready, b_ready, ea, eb); end
            n_cmp++; if (hazard !== eh) begin n_err++; $display("FAIL rand.hazard c%0d got %0b want %0b", c, hazard, eh); end
            n_cmp++; if (busy !== m_busy) begin n_err++; $display("FAIL rand.busy c%0d got %h want %h", c, busy, m_busy); end
            n_cmp++; if (we !== m_we) begin n_err++; $display("FAIL rand.we c%0d got %0b want %0b", c, we, m_we); end
            if (m_we) begin
                n_cmp++; if (wa !== m_wa || wd !== m_wd) begin n_err++; $display("FAIL rand.wport c%0d got %0d/%h want %0d/%h", c, wa, wd, m_wa, m_wd); end
            end
            for (int r = 1; r < 8; r++) begin
                n_cmp++; if (rf[r] !== m_rf[r]) begin n_err++; $display("FAIL rand.rf%0d c%0d got %h want %h", r, c, rf[r], m_rf[r]); end
            end
            if (m_we) begin
                m_rf[m_wa] = m_wd;
                m_busy[m_wa] = 1'b0;
            end
            if (alloc_v && !eh && alloc_a != 0) m_busy[alloc_a] = 1'b1;
            if (ea) begin
                m_we = (a_addr != 0); m_wa = a_addr; m_wd = a_data; last_b = 0;
            end else if (eb) begin
                m_we = (b_addr != 0); m_wa = b_addr; m_wd = b_data; last_b = 1;
            end else begin
                m_we = 0;
            end
            a_hold = a_valid && !ea;
            b_hold = b_valid && !eb;
            next();
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_a_only();
        test_tie();
        test_scoreboard();
        test_waw();
        test_r0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
